// File: rtl/rv_plic_engine.sv
// rv_plic_engine: per-source interrupt gateways (level/edge with edge counting, MSI injection)
// followed by per-target max-priority selection with registered irq outputs.
module rv_plic_engine #(
   parameter int NumSrc    = 64,
   parameter int NumTarget = 2,
   parameter int MaxPrio   = 7,
   parameter int EdgeCntW  = 4,
   parameter int PrioW     = $clog2(MaxPrio + 1),
   parameter int SrcW      = $clog2(NumSrc)
) (
   input  logic                        clk_i,
   input  logic                        rst_ni,
   input  logic [NumSrc-1:0]           src_i,
   input  logic [NumSrc-1:0]           le_i,
   input  logic                        msi_valid_i,
   input  logic [SrcW-1:0]             msi_id_i,
   input  logic [NumSrc*PrioW-1:0]     prio_i,
   input  logic [NumTarget*NumSrc-1:0] ie_i,
   input  logic [NumTarget*PrioW-1:0]  threshold_i,
   input  logic [NumTarget-1:0]        claim_i,
   input  logic [NumTarget-1:0]        complete_i,
   input  logic [NumTarget*SrcW-1:0]   complete_id_i,
   output logic [NumSrc-1:0]           ip_o,
   output logic [NumTarget-1:0]        irq_o,
   output logic [NumTarget*SrcW-1:0]   irq_id_o
);

   typedef enum logic [1:0] {IDLE, PEND, FLIGHT} gw_state_e;

   function automatic logic [EdgeCntW-1:0] cnt_sat_inc(input logic [EdgeCntW-1:0] v);
      return (&v) ? v : v + EdgeCntW'(1);
   endfunction

   logic [NumSrc-1:0]    src_q, le_q, ip, msi_hit, claim_hit, complete_hit;
   logic [NumTarget-1:0] irq_d, irq_p1;
   logic [SrcW-1:0]      irq_id_d  [NumTarget];
   logic [SrcW-1:0]      irq_id_p1 [NumTarget];

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         src_q <= '0;
         le_q  <= '0;
      end else begin
         src_q <= src_i;
         le_q  <= le_i;
      end
   end

   // Source 0 is reserved: its MSI, claim and complete hits stay 0.
   always_comb begin
      msi_hit      = '0;
      claim_hit    = '0;
      complete_hit = '0;
      for (int s = 1; s < NumSrc; s++) begin
         msi_hit[s] = msi_valid_i && (msi_id_i == SrcW'(s));
         for (int t = 0; t < NumTarget; t++) begin
            if (claim_i[t] && (irq_id_p1[t] == SrcW'(s)))
               claim_hit[s] = 1'b1;
            if (complete_i[t] && (complete_id_i[t*SrcW +: SrcW] == SrcW'(s)))
               complete_hit[s] = 1'b1;
         end
      end
   end

   // Gateway stage: one IDLE/PEND/FLIGHT machine plus saturating event counter per source.
   for (genvar s = 0; s < NumSrc; s++) begin : g_gw
      gw_state_e           state_q, state_d;
      logic [EdgeCntW-1:0] cnt_q, cnt_d, cnt_inc;
      logic                edge_ev, ev, inc;

      assign edge_ev = src_i[s] & ~src_q[s];
      assign ev      = (s != 0) && ((le_i[s] ? edge_ev : src_i[s]) || msi_hit[s]);
      // A held level is not an event to count; MSIs are counted in either mode.
      assign inc     = le_i[s] ? ev : msi_hit[s];
      assign cnt_inc = inc ? cnt_sat_inc(cnt_q) : cnt_q;

      always_ff @(posedge clk_i or negedge rst_ni) begin
         if (!rst_ni) begin
            state_q <= IDLE;
            cnt_q   <= '0;
         end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
         end
      end

      always_comb begin
         state_d = state_q;
         cnt_d   = cnt_q;
         case (state_q)
            IDLE: begin
               if (ev) state_d = PEND;
            end
            PEND: begin
               cnt_d = cnt_inc;
               if (claim_hit[s]) state_d = FLIGHT;
            end
            FLIGHT: begin
               cnt_d = cnt_inc;
               if (complete_hit[s]) begin
                  if (cnt_inc != '0) begin
                     state_d = PEND;
                     cnt_d   = cnt_inc - EdgeCntW'(1);
                  end else begin
                     state_d = IDLE;
                  end
               end
            end
            default: state_d = IDLE;
         endcase
         // Switching a source back to level mode discards any queued edges.
         if (le_q[s] && !le_i[s]) cnt_d = '0;
      end

      assign ip[s] = (state_q == PEND);
   end

   // Selection stage: highest priority above threshold, ascending scan keeps the lowest ID on ties.
   always_comb begin
      logic [PrioW-1:0] best;
      logic [PrioW-1:0] p;
      irq_d = '0;
      best  = '0;
      p     = '0;
      for (int t = 0; t < NumTarget; t++) begin
         best         = '0;
         irq_id_d[t]  = '0;
         for (int s = 0; s < NumSrc; s++) begin
            p = prio_i[s*PrioW +: PrioW];
            if (ip[s] && ie_i[t*NumSrc + s] && (p > threshold_i[t*PrioW +: PrioW]) && (p > best)) begin
               best        = p;
               irq_id_d[t] = SrcW'(s);
            end
         end
         irq_d[t] = (best != '0);
      end
   end

   // Output register stage.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         irq_p1 <= '0;
         for (int t = 0; t < NumTarget; t++) irq_id_p1[t] <= '0;
      end else begin
         irq_p1    <= irq_d;
         irq_id_p1 <= irq_id_d;
      end
   end

   assign ip_o  = ip;
   assign irq_o = irq_p1;
   for (genvar t = 0; t < NumTarget; t++) begin : g_id_out
      assign irq_id_o[t*SrcW +: SrcW] = irq_id_p1[t];
   end

endmodule

// File: tb/tb_rv_plic_engine.sv
// Directed bench for rv_plic_engine: stimulus pushes hand-computed expectations into a
// scoreboard queue, a separate monitor pops and compares them on the falling clock edge.
module tb_rv_plic_engine;
  localparam int NumSrc    = 64;
  localparam int NumTarget = 2;
  localparam int MaxPrio   = 7;
  localparam int EdgeCntW  = 2;
  localparam int PrioW     = 3;
  localparam int SrcW      = 6;

  logic                        clk = 1'b0;
  logic                        rst_n;
  logic [NumSrc-1:0]           src, le;
  logic                        msi_valid;
  logic [SrcW-1:0]             msi_id;
  logic [NumSrc*PrioW-1:0]     prio;
  logic [NumTarget*NumSrc-1:0] ie;
  logic [NumTarget*PrioW-1:0]  thr;
  logic [NumTarget-1:0]        claim, complete;
  logic [NumTarget*SrcW-1:0]   complete_id;
  logic [NumSrc-1:0]           ip;
  logic [NumTarget-1:0]        irq;
  logic [NumTarget*SrcW-1:0]   irq_id;

  rv_plic_engine #(
    .NumSrc(NumSrc), .NumTarget(NumTarget), .MaxPrio(MaxPrio), .EdgeCntW(EdgeCntW)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n), .src_i(src), .le_i(le),
    .msi_valid_i(msi_valid), .msi_id_i(msi_id), .prio_i(prio), .ie_i(ie),
    .threshold_i(thr), .claim_i(claim), .complete_i(complete),
    .complete_id_i(complete_id), .ip_o(ip), .irq_o(irq), .irq_id_o(irq_id)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [63:0] ip;
    logic [1:0]  irq;
    logic [5:0]  id0;
    logic [5:0]  id1;
  } exp_t;

  exp_t sb_q[$];
  int   errors = 0;
  int   checks = 0;
  logic stim_done = 1'b0;

  function automatic logic [63:0] b(input int n);
    return 64'd1 << n;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string n, input logic [63:0] eip, input logic [1:0] eirq,
                     input int e0, input int e1);
    exp_t e;
    e.name = n;
    e.ip   = eip;
    e.irq  = eirq;
    e.id0  = 6'(e0);
    e.id1  = 6'(e1);
    sb_q.push_back(e);
  endtask

  task automatic cfg_src(input int s, input int p, input logic e0, input logic e1);
    prio[s*PrioW +: PrioW] = 3'(p);
    ie[s]                  = e0;
    ie[NumSrc + s]         = e1;
  endtask

  task automatic pulse_claim(input logic [1:0] c);
    claim = c;
    tick();
    claim = '0;
  endtask

  task automatic pulse_complete(input logic [1:0] c, input int i0, input int i1);
    complete    = c;
    complete_id = {6'(i1), 6'(i0)};
    tick();
    complete    = '0;
  endtask

  task automatic pulse_msi(input int id);
    msi_valid = 1'b1;
    msi_id    = 6'(id);
    tick();
    msi_valid = 1'b0;
  endtask

  task automatic edges9(input int n);
    for (int i = 0; i < n; i++) begin
      src[9] = 1'b1;
      tick();
      src[9] = 1'b0;
      tick();
    end
  endtask

  task automatic round9(input logic rep);
    pulse_claim(2'b01);
    pulse_complete(2'b01, 9, 0);
    chk("edge_round_ip", rep ? b(9) : 64'd0, 2'b00, 0, 0);
    tick();
    chk("edge_round_irq", rep ? b(9) : 64'd0, rep ? 2'b01 : 2'b00, rep ? 9 : 0, 0);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      while (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        checks++;
        if (ip !== e.ip) begin
          errors++;
          $display("FAIL %s: got ip=%h, want ip=%h", e.name, ip, e.ip);
        end
        if (irq !== e.irq) begin
          errors++;
          $display("FAIL %s: got irq=%b, want irq=%b", e.name, irq, e.irq);
        end
        if (irq_id[5:0] !== e.id0) begin
          errors++;
          $display("FAIL %s: got id0=%0d, want id0=%0d", e.name, irq_id[5:0], e.id0);
        end
        if (irq_id[11:6] !== e.id1) begin
          errors++;
          $display("FAIL %s: got id1=%0d, want id1=%0d", e.name, irq_id[11:6], e.id1);
        end
      end
      if (stim_done) begin
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
      end
    end
  end

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: bench did not complete, got timeout, want summary");
    $fatal(1);
  end

  initial begin : stimulus
    rst_n = 1'b0; src = '0; le = '0; msi_valid = 1'b0; msi_id = '0;
    prio = '0; ie = '0; thr = '0; claim = '0; complete = '0; complete_id = '0;
    tick(); tick();
    chk("reset", 64'd0, 2'b00, 0, 0);
    tick();
    rst_n = 1'b1;
    tick();

    // Level source 5
    cfg_src(5, 3, 1'b1, 1'b0);
    src[5] = 1'b1;
    tick();                 chk("lvl_pend", b(5), 2'b00, 0, 0);
    tick();                 chk("lvl_irq", b(5), 2'b01, 5, 0);
    pulse_claim(2'b01);     chk("lvl_claim_stale", 64'd0, 2'b01, 5, 0);
    tick();                 chk("lvl_claimed", 64'd0, 2'b00, 0, 0);
    pulse_complete(2'b01, 5, 0);
    tick();                 chk("lvl_repend", b(5), 2'b00, 0, 0);
    tick();                 chk("lvl_repend_irq", b(5), 2'b01, 5, 0);
    src[5] = 1'b0;
    pulse_claim(2'b01);
    pulse_complete(2'b01, 5, 0);
    tick();                 chk("lvl_done", 64'd0, 2'b00, 0, 0);
    cfg_src(5, 0, 1'b0, 1'b0);

    // Edge counting on source 9: three edges, then six (saturating at 3)
    le[9] = 1'b1;
    cfg_src(9, 2, 1'b1, 1'b0);
    edges9(3);              chk("edge3_pend", b(9), 2'b01, 9, 0);
    round9(1'b1); round9(1'b1); round9(1'b0);
    edges9(6);              chk("edge6_pend", b(9), 2'b01, 9, 0);
    round9(1'b1); round9(1'b1); round9(1'b1); round9(1'b0);
    le[9] = 1'b0;
    cfg_src(9, 0, 1'b0, 1'b0);
    tick();

    // Arbitration: 3 and 7 at prio 4, 12 at prio 6; target 1 sees only 3 and 7
    cfg_src(3, 4, 1'b1, 1'b1);
    cfg_src(7, 4, 1'b1, 1'b1);
    cfg_src(12, 6, 1'b1, 1'b0);
    thr[5:3] = 3'd4;
    src[3] = 1'b1; src[7] = 1'b1; src[12] = 1'b1;
    tick();                 chk("arb_pend", b(3) | b(7) | b(12), 2'b00, 0, 0);
    tick();                 chk("arb_max", b(3) | b(7) | b(12), 2'b01, 12, 0);
    pulse_claim(2'b01);
    tick();                 chk("arb_tie_low", b(3) | b(7), 2'b01, 3, 0);
    thr[5:3] = 3'd3;
    tick();                 chk("arb_thr_lower", b(3) | b(7), 2'b11, 3, 3);
    thr[2:0] = 3'd7;
    tick();                 chk("arb_thr_max", b(3) | b(7), 2'b10, 0, 3);
    thr = '0;
    src[3] = 1'b0; src[7] = 1'b0; src[12] = 1'b0;
    pulse_complete(2'b01, 12, 0);
    pulse_claim(2'b01);
    tick();                 chk("arb_next", b(7), 2'b11, 7, 7);
    pulse_claim(2'b10);
    tick();
    pulse_complete(2'b11, 3, 7);
    chk("arb_done", 64'd0, 2'b00, 0, 0);
    cfg_src(3, 0, 1'b0, 1'b0);
    cfg_src(7, 0, 1'b0, 1'b0);
    cfg_src(12, 0, 1'b0, 1'b0);
    tick();

    // MSI to level-mode source 20 with src low
    cfg_src(20, 5, 1'b1, 1'b1);
    pulse_msi(20);          chk("msi_pend", b(20), 2'b00, 0, 0);
    tick();                 chk("msi_irq", b(20), 2'b11, 20, 20);
    pulse_complete(2'b01, 20, 0);
    chk("cmpl_in_pend_ignored", b(20), 2'b11, 20, 20);
    pulse_claim(2'b11);
    tick();                 chk("dual_claim", 64'd0, 2'b00, 0, 0);
    pulse_msi(20);          chk("msi_in_flight", 64'd0, 2'b00, 0, 0);
    pulse_complete(2'b01, 20, 0);
    chk("msi_repend", b(20), 2'b00, 0, 0);
    tick();                 chk("msi_repend_irq", b(20), 2'b11, 20, 20);
    pulse_claim(2'b01);
    pulse_complete(2'b01, 20, 0);
    tick();                 chk("msi_idle", 64'd0, 2'b00, 0, 0);
    pulse_msi(0);           chk("msi_id0_ip", 64'd0, 2'b00, 0, 0);
    tick();                 chk("msi_id0_irq", 64'd0, 2'b00, 0, 0);
    cfg_src(20, 0, 1'b0, 1'b0);

    // Asynchronous reset while source 9 is in FLIGHT with one queued edge
    le[9] = 1'b1;
    cfg_src(9, 2, 1'b1, 1'b0);
    edges9(2);
    pulse_claim(2'b01);
    rst_n = 1'b0;           chk("rst_async", 64'd0, 2'b00, 0, 0);
    tick();
    rst_n = 1'b1;
    tick();
    src[9] = 1'b1;
    tick();
    src[9] = 1'b0;
    tick();                 chk("post_rst_irq", b(9), 2'b01, 9, 0);
    pulse_claim(2'b01);
    pulse_complete(2'b01, 9, 0);
    chk("post_rst_cnt0", 64'd0, 2'b00, 0, 0);
    tick();                 chk("post_rst_idle", 64'd0, 2'b00, 0, 0);

    stim_done = 1'b1;
  end

endmodule
